// File: rtl/wb_outq_pkg.sv
// Shared types for the writeback output queue.
// Holds the queued entry record and the field width constants.
package wb_outq_pkg;

  localparam int REG_W = 5;
  localparam int XLEN  = 64;
  localparam int PC_W  = 64;

  typedef struct packed {
    logic [REG_W-1:0] dst;
    logic [XLEN-1:0]  result;
    logic [PC_W-1:0]  pc;
    logic             wb_en;
  } wb_entry_t;

endpackage

// File: rtl/wb_outq_fwd.sv
// Forwarding lookup over the queued writeback entries.
// Ports: entries/rd_ptr/count (queue state), fwd_rs in; fwd_hit/fwd_value out.
import wb_outq_pkg::*;

module wb_outq_fwd #(
  parameter int DEPTH = 2
) (
  input  wb_entry_t                     entries [DEPTH],
  input  logic [$clog2(DEPTH)-1:0]      rd_ptr,
  input  logic [$clog2(DEPTH):0]        count,
  input  logic [REG_W-1:0]              fwd_rs,
  output logic                          fwd_hit,
  output logic [XLEN-1:0]               fwd_value
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] w_idx   [DEPTH];
  logic [DEPTH-1:0] w_match;

  // Slot k holds the k-th oldest entry, counted from the read pointer.
  for (genvar k = 0; k < DEPTH; k++) begin : g_age
    assign w_idx[k]   = rd_ptr + PTR_W'(k);
    assign w_match[k] = (CNT_W'(k) < count)
                      && entries[w_idx[k]].wb_en
                      && (entries[w_idx[k]].dst == fwd_rs)
                      && (fwd_rs != '0);
  end

  // Later (younger) matches override earlier ones.
  always_comb begin
    fwd_hit   = 1'b0;
    fwd_value = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (w_match[k]) begin
        fwd_hit   = 1'b1;
        fwd_value = entries[w_idx[k]].result;
      end
    end
  end

endmodule

// File: rtl/wb_outq.sv
// Per-pipe in-order writeback output queue with operand forwarding lookup.
// Ports: clk, rst_n; in_* (pipe side), wb_* (arbiter side), fwd_rs/fwd_hit/
// fwd_value (bypass lookup), count. Option: WB_OUTQ_BYPASS_EN (empty bypass).
import wb_outq_pkg::*;

module wb_outq #(
  parameter int DEPTH = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [REG_W-1:0]        in_dst,
  input  logic [XLEN-1:0]         in_result,
  input  logic [PC_W-1:0]         in_pc,
  input  logic                    in_wb_en,
  output logic                    wb_valid,
  input  logic                    wb_ready,
  output logic [REG_W-1:0]        wb_dst,
  output logic [XLEN-1:0]         wb_result,
  output logic [PC_W-1:0]         wb_pc,
  output logic                    wb_wb_en,
  input  logic [REG_W-1:0]        fwd_rs,
  output logic                    fwd_hit,
  output logic [XLEN-1:0]         fwd_value,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd;
  logic [PTR_W-1:0] r_wr;
  logic [CNT_W-1:0] r_cnt;

  wb_entry_t w_in;
  wb_entry_t w_head;
  logic      w_empty;
  logic      w_push;
  logic      w_pop;

  assign w_in     = '{dst: in_dst, result: in_result,
                      pc: in_pc, wb_en: in_wb_en};
  assign w_empty  = (r_cnt == '0);
  assign in_ready = (r_cnt != CNT_W'(DEPTH));
  assign count    = r_cnt;

`ifdef WB_OUTQ_BYPASS_EN
  logic w_bypass;

  // An empty queue shows the incoming entry directly; if taken
  // immediately it never occupies storage.
  assign w_head   = w_empty ? w_in : r_mem[r_rd];
  assign wb_valid = w_empty ? in_valid : 1'b1;
  assign w_bypass = w_empty && in_valid && wb_ready;
  assign w_push   = in_valid && in_ready && !w_bypass;
  assign w_pop    = !w_empty && wb_ready;
`else
  assign w_head   = r_mem[r_rd];
  assign wb_valid = !w_empty;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = wb_valid && wb_ready;
`endif

  assign wb_dst    = w_head.dst;
  assign wb_result = w_head.result;
  assign wb_pc     = w_head.pc;
  assign wb_wb_en  = w_head.wb_en;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr] <= w_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  wb_outq_fwd #(
    .DEPTH(DEPTH)
  ) u_fwd (
    .entries  (r_mem),
    .rd_ptr   (r_rd),
    .count    (r_cnt),
    .fwd_rs   (fwd_rs),
    .fwd_hit  (fwd_hit),
    .fwd_value(fwd_value)
  );

endmodule

// File: tb/tb_wb_outq.sv
// Self-checking bench for wb_outq against a queue-based reference model.
// Directed scenarios followed by randomized traffic.
module tb_wb_outq;

  localparam int DEPTH = 2;
`ifdef WB_OUTQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_dst = '0;
  logic [63:0] in_result = '0;
  logic [63:0] in_pc = '0;
  logic        in_wb_en = 1'b0;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic [4:0]  wb_dst;
  logic [63:0] wb_result;
  logic [63:0] wb_pc;
  logic        wb_wb_en;
  logic [4:0]  fwd_rs = '0;
  logic        fwd_hit;
  logic [63:0] fwd_value;
  logic [$clog2(DEPTH):0] count;

  wb_outq #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_dst(in_dst), .in_result(in_result),
    .in_pc(in_pc), .in_wb_en(in_wb_en),
    .wb_valid(wb_valid), .wb_ready(wb_ready),
    .wb_dst(wb_dst), .wb_result(wb_result),
    .wb_pc(wb_pc), .wb_wb_en(wb_wb_en),
    .fwd_rs(fwd_rs), .fwd_hit(fwd_hit),
    .fwd_value(fwd_value), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  dst;
    logic [63:0] res;
    logic [63:0] pc;
    bit          en;
  } ent_t;

  ent_t q[$];
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, compare against the model, clock it.
  task automatic step(input bit v, input logic [4:0] d,
                      input logic [63:0] r, input bit e,
                      input bit rdy, input logic [4:0] rs);
    int n;
    bit ev, eh, pop, push, byp;
    ent_t h, cur;
    logic [63:0] efv;
    @(negedge clk);
    in_valid  = v;
    in_dst    = d;
    in_result = r;
    in_pc     = r ^ 64'hA5A5_0000_0000_1000;
    in_wb_en  = e;
    wb_ready  = rdy;
    fwd_rs    = rs;
    #1;
    cur = '{dst: d, res: r, pc: in_pc, en: e};
    n = q.size();
    h = cur;
    if (BYP && n == 0) ev = v;
    else begin
      ev = (n != 0);
      if (n != 0) h = q[0];
    end
    chk("wb_valid", 64'(wb_valid), 64'(ev));
    chk("count", 64'(count), 64'(n));
    chk("in_ready", 64'(in_ready), 64'(n != DEPTH));
    if (ev) begin
      chk("wb_dst", 64'(wb_dst), 64'(h.dst));
      chk("wb_result", wb_result, h.res);
      chk("wb_pc", wb_pc, h.pc);
      chk("wb_wb_en", 64'(wb_wb_en), 64'(h.en));
    end
    eh = 1'b0;
    efv = '0;
    foreach (q[i]) begin
      if (q[i].en && q[i].dst == rs && rs != 0) begin
        eh = 1'b1;
        efv = q[i].res;
      end
    end
    chk("fwd_hit", 64'(fwd_hit), 64'(eh));
    if (eh) chk("fwd_value", fwd_value, efv);
    pop  = ev && rdy;
    byp  = BYP && n == 0 && pop;
    push = v && (n != DEPTH) && !byp;
    @(posedge clk);
    if (pop && n > 0) void'(q.pop_front());
    if (push) q.push_back(cur);
  endtask

  task automatic drain();
    repeat (DEPTH + 1) step(1'b0, 5'd0, 64'd0, 1'b0, 1'b1, 5'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk("rst_valid", 64'(wb_valid), 64'(0));
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_ready", 64'(in_ready), 64'(1));
    chk("rst_fwd", 64'(fwd_hit), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // single push, then visible to output and forwarding
    step(1'b1, 5'd5, 64'h1234, 1'b1, 1'b0, 5'd5);
    #1;
    chk("p1_valid", 64'(wb_valid), 64'(1));
    chk("p1_dst", 64'(wb_dst), 64'(5));
    chk("p1_count", 64'(count), 64'(1));
    chk("p1_hit", 64'(fwd_hit), 64'(1));
    chk("p1_val", fwd_value, 64'h1234);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd5);
    drain();

    // fill, then pop while full blocks the push
    step(1'b1, 5'd1, 64'hA, 1'b1, 1'b0, 5'd0);
    step(1'b1, 5'd2, 64'hB, 1'b1, 1'b0, 5'd0);
    #1;
    chk("full_ready", 64'(in_ready), 64'(0));
    chk("full_count", 64'(count), 64'(2));
    step(1'b1, 5'd3, 64'hC, 1'b1, 1'b1, 5'd0);
    #1;
    chk("blk_count", 64'(count), 64'(1));
    chk("blk_dst", 64'(wb_dst), 64'(2));
    step(1'b1, 5'd3, 64'hC, 1'b1, 1'b0, 5'd0);
    #1;
    chk("acc_count", 64'(count), 64'(2));
    drain();

    // youngest match wins; rs=0 and wb_en=0 never hit
    step(1'b1, 5'd7, 64'h1, 1'b1, 1'b0, 5'd7);
    step(1'b1, 5'd7, 64'h2, 1'b1, 1'b0, 5'd7);
    #1;
    chk("young_val", fwd_value, 64'h2);
    step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd0);
    drain();
    step(1'b1, 5'd9, 64'h99, 1'b0, 1'b0, 5'd9);
    #1;
    chk("noen_hit", 64'(fwd_hit), 64'(0));
    drain();

    // streaming: order preserved across pointer wrap
    for (int i = 0; i < 12; i++)
      step(1'b1, 5'(i + 1), 64'(100 + i), 1'b1, 1'b1, 5'(i));
    drain();

    if (BYP) begin
      step(1'b1, 5'd3, 64'h33, 1'b1, 1'b1, 5'd3);
      #1;
      chk("byp_count", 64'(count), 64'(0));
      step(1'b1, 5'd3, 64'h44, 1'b1, 1'b0, 5'd3);
      #1;
      chk("byp_cnt1", 64'(count), 64'(1));
      chk("byp_dst", 64'(wb_dst), 64'(3));
      step(1'b0, 5'd0, 64'd0, 1'b0, 1'b0, 5'd3);
      drain();
    end

    // async reset with a full queue
    step(1'b1, 5'd4, 64'h4, 1'b1, 1'b0, 5'd0);
    step(1'b1, 5'd6, 64'h6, 1'b1, 1'b0, 5'd0);
    @(negedge clk);
    in_valid = 1'b0;
    wb_ready = 1'b0;
    fwd_rs   = 5'd4;
    #1;
    chk("pre_rst_count", 64'(count), 64'(2));
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(wb_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_ready", 64'(in_ready), 64'(1));
    chk("arst_fwd", 64'(fwd_hit), 64'(0));
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;

    // randomized traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 3)),
           {$urandom, $urandom}, 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 2) == 0), 5'($urandom_range(0, 3)));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
